// File: rtl/baud_tick_gen.sv
// baud_tick_gen: baud-rate tick generator for the UART TX/RX datapaths.
//   A CNT_W-bit prescaler emits an oversample tick every (div_q+1) clocks.
//   An OSR-deep phase counter turns those ticks into a mid-bit strobe and
//   an end-of-bit strobe. The divisor is reprogrammable at run time and
//   takes effect only at a tick boundary, so no period is ever cut short
//   or stretched.
// Ports:
//   clk           clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   i_en          count enable; low holds all counters
//   i_restart     synchronous clear of prescaler and phase (beats i_en)
//   i_div_load    1-cycle strobe: capture i_div_in as the pending divisor
//   i_div_in      new divisor (oversample period = i_div_in + 1)
//   o_os_tick     1-cycle pulse per oversample period
//   o_mid_tick    1-cycle pulse at the middle of each bit
//   o_bit_tick    1-cycle pulse at the end of each bit
//   o_os_idx      current oversample phase, 0..OSR-1
//   o_div_pending captured divisor not yet applied
module baud_tick_gen #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DIV_DEFAULT = 324,
  parameter int unsigned OSR         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic                     i_restart,
  input  logic                     i_div_load,
  input  logic [CNT_W-1:0]         i_div_in,
  output logic                     o_os_tick,
  output logic                     o_mid_tick,
  output logic                     o_bit_tick,
  output logic [$clog2(OSR)-1:0]   o_os_idx,
  output logic                     o_div_pending
);

  localparam int unsigned OSR_W = $clog2(OSR);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);
  localparam logic [OSR_W-1:0] IDX_LAST = OSR_W'(OSR - 1);
  localparam logic [OSR_W-1:0] IDX_MID  = OSR_W'(OSR / 2 - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_div_pend_val;
  logic             r_div_pend;
  logic [OSR_W-1:0] r_os_idx;
  logic             r_os_tick;
  logic             r_mid_tick;
  logic             r_bit_tick;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_q_nxt;
  logic [CNT_W-1:0] w_div_pend_val_nxt;
  logic             w_div_pend_nxt;
  logic [OSR_W-1:0] w_os_idx_nxt;
  logic             w_os_tick_nxt;
  logic             w_mid_tick_nxt;
  logic             w_bit_tick_nxt;
  logic             w_wrap;

  // >= rather than == so a counter left above a shrunken divisor still wraps.
  assign w_wrap = (r_cnt >= r_div_q);

  // Next-state logic for prescaler, phase counter and divisor staging.
  always_comb begin
    w_cnt_nxt          = r_cnt;
    w_div_q_nxt        = r_div_q;
    w_div_pend_val_nxt = r_div_pend_val;
    w_div_pend_nxt     = r_div_pend;
    w_os_idx_nxt       = r_os_idx;
    w_os_tick_nxt      = 1'b0;
    w_mid_tick_nxt     = 1'b0;
    w_bit_tick_nxt     = 1'b0;

    if (i_restart) begin
      // Re-align to a fresh bit; a divisor offered now wins over the staged one.
      w_cnt_nxt    = '0;
      w_os_idx_nxt = '0;
      if (i_div_load) begin
        w_div_q_nxt        = i_div_in;
        w_div_pend_val_nxt = i_div_in;
        w_div_pend_nxt     = 1'b0;
      end else if (r_div_pend) begin
        w_div_q_nxt    = r_div_pend_val;
        w_div_pend_nxt = 1'b0;
      end
    end else begin
      if (i_en) begin
        if (w_wrap) begin
          w_cnt_nxt     = '0;
          w_os_tick_nxt = 1'b1;
          if (r_div_pend) begin
            w_div_q_nxt    = r_div_pend_val;
            w_div_pend_nxt = 1'b0;
          end
          if (r_os_idx == IDX_LAST) begin
            w_os_idx_nxt   = '0;
            w_bit_tick_nxt = 1'b1;
          end else begin
            w_os_idx_nxt = r_os_idx + OSR_W'(1);
          end
          w_mid_tick_nxt = (r_os_idx == IDX_MID);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      // A load coinciding with a wrap stays pending; the older value was used above.
      if (i_div_load) begin
        w_div_pend_val_nxt = i_div_in;
        w_div_pend_nxt     = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_div_q        <= DIV_RST;
      r_div_pend_val <= DIV_RST;
      r_div_pend     <= 1'b0;
      r_os_idx       <= '0;
      r_os_tick      <= 1'b0;
      r_mid_tick     <= 1'b0;
      r_bit_tick     <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_div_q        <= w_div_q_nxt;
      r_div_pend_val <= w_div_pend_val_nxt;
      r_div_pend     <= w_div_pend_nxt;
      r_os_idx       <= w_os_idx_nxt;
      r_os_tick      <= w_os_tick_nxt;
      r_mid_tick     <= w_mid_tick_nxt;
      r_bit_tick     <= w_bit_tick_nxt;
    end
  end

  assign o_os_tick     = r_os_tick;
  assign o_mid_tick    = r_mid_tick;
  assign o_bit_tick    = r_bit_tick;
  assign o_os_idx      = r_os_idx;
  assign o_div_pending = r_div_pend;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed checks of baud_tick_gen with default parameters
// (divisor 324, 16x oversampling). Tick latencies are counted in clock
// edges and compared with hand-computed values.
module tb_baud_tick_gen;

  localparam int unsigned CNT_W = 26;

  logic             clk;
  logic             rst_n;
  logic             i_en;
  logic             i_restart;
  logic             i_div_load;
  logic [CNT_W-1:0] i_div_in;
  logic             o_os_tick;
  logic             o_mid_tick;
  logic             o_bit_tick;
  logic [3:0]       o_os_idx;
  logic             o_div_pending;

  int errors = 0;
  int checks = 0;
  int n;

  baud_tick_gen #(.CNT_W(CNT_W), .DIV_DEFAULT(324), .OSR(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_restart     (i_restart),
    .i_div_load    (i_div_load),
    .i_div_in      (i_div_in),
    .o_os_tick     (o_os_tick),
    .o_mid_tick    (o_mid_tick),
    .o_bit_tick    (o_bit_tick),
    .o_os_idx      (o_os_idx),
    .o_div_pending (o_div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until the selected tick (0=os, 1=mid, 2=bit) is seen; -1 if budget expires.
  task automatic wait_tick(input int sel, input int budget, output int cnt);
    int  k;
    logic s;
    k   = 0;
    cnt = -1;
    while (k < budget && cnt < 0) begin
      step();
      k++;
      s = (sel == 0) ? o_os_tick : (sel == 1) ? o_mid_tick : o_bit_tick;
      if (s) cnt = k;
    end
  endtask

  task automatic pulse_load(input logic [CNT_W-1:0] val, input logic with_restart);
    i_div_load = 1'b1;
    i_div_in   = val;
    i_restart  = with_restart;
    step();
    i_div_load = 1'b0;
    i_restart  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    i_en       = 1'b0;
    i_restart  = 1'b0;
    i_div_load = 1'b0;
    i_div_in   = '0;

    // Reset values
    #12;
    check("rst_os_tick", 32'(o_os_tick), 0);
    check("rst_mid_tick", 32'(o_mid_tick), 0);
    check("rst_bit_tick", 32'(o_bit_tick), 0);
    check("rst_os_idx", 32'(o_os_idx), 0);
    check("rst_pending", 32'(o_div_pending), 0);

    // Default divisor: os every 325, mid at 2600, bit at 5200
    @(posedge clk);
    #5;
    rst_n = 1'b1;
    i_en  = 1'b1;
    wait_tick(0, 400, n);   check("os_first", 32'(n), 325);
    step();                 check("os_one_cycle", 32'(o_os_tick), 0);
    wait_tick(0, 400, n);   check("os_second", 32'(n), 324);
    wait_tick(1, 3000, n);  check("mid_first", 32'(n), 1950);
    check("mid_with_os", 32'(o_os_tick), 1);
    check("mid_os_idx", 32'(o_os_idx), 8);
    wait_tick(2, 3000, n);  check("bit_first", 32'(n), 2600);
    check("bit_os_idx", 32'(o_os_idx), 0);
    check("bit_no_mid", 32'(o_mid_tick), 0);
    wait_tick(2, 6000, n);  check("bit_period", 32'(n), 5200);

    // Enable low for 50 clk at cnt=100
    for (int i = 0; i < 100; i++) step();
    i_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check("hold_no_os", 32'(o_os_tick), 0);
      check("hold_os_idx", 32'(o_os_idx), 0);
    end
    i_en = 1'b1;
    wait_tick(0, 400, n);   check("hold_resume", 32'(n), 225);
    check("hold_idx_after", 32'(o_os_idx), 1);

    // Divisor 9 loaded mid-period: running period completes unchanged
    for (int i = 0; i < 100; i++) step();
    pulse_load(CNT_W'(9), 1'b0);
    check("load9_pending", 32'(o_div_pending), 1);
    wait_tick(0, 400, n);   check("load9_old_period", 32'(n), 224);
    check("load9_applied", 32'(o_div_pending), 0);
    wait_tick(0, 50, n);    check("div9_period_a", 32'(n), 10);
    wait_tick(0, 50, n);    check("div9_period_b", 32'(n), 10);

    // Restart applies a pending divisor immediately
    n = 0;
    while (o_os_idx != 4'd11 && n < 400) begin
      step();
      n++;
    end
    check("reach_idx11", 32'(o_os_idx), 11);
    for (int i = 0; i < 5; i++) step();
    pulse_load(CNT_W'(324), 1'b0);
    check("load324_pending", 32'(o_div_pending), 1);
    step();
    step();
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check("restart_idx", 32'(o_os_idx), 0);
    check("restart_no_os", 32'(o_os_tick), 0);
    check("restart_pend_used", 32'(o_div_pending), 0);
    wait_tick(0, 400, n);   check("restart_os", 32'(n), 325);
    check("restart_idx_after", 32'(o_os_idx), 1);

    // Restart with simultaneous load of 4
    pulse_load(CNT_W'(4), 1'b1);
    check("rl4_pending", 32'(o_div_pending), 0);
    wait_tick(0, 50, n);    check("rl4_os_a", 32'(n), 5);
    wait_tick(0, 50, n);    check("rl4_os_b", 32'(n), 5);

    // Divisor 0: os every clk, bit every 16, mid 8 after bit
    pulse_load(CNT_W'(0), 1'b0);
    check("load0_pending", 32'(o_div_pending), 1);
    wait_tick(0, 50, n);    check("load0_old_period", 32'(n), 4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("div0_os_every", 32'(o_os_tick), 1);
    end
    wait_tick(2, 40, n);
    wait_tick(1, 40, n);    check("div0_bit_to_mid", 32'(n), 8);
    wait_tick(2, 40, n);    check("div0_mid_to_bit", 32'(n), 8);
    wait_tick(2, 40, n);    check("div0_bit_period", 32'(n), 16);

    // Load on a wrap edge stays pending; async reset clears it
    pulse_load(CNT_W'(50), 1'b1);
    for (int i = 0; i < 50; i++) step();
    pulse_load(CNT_W'(7), 1'b0);
    check("wrapload_os", 32'(o_os_tick), 1);
    check("wrapload_pending", 32'(o_div_pending), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_os", 32'(o_os_tick), 0);
    check("async_pending", 32'(o_div_pending), 0);
    check("async_idx", 32'(o_os_idx), 0);
    @(posedge clk);
    #5;
    rst_n = 1'b1;
    wait_tick(0, 400, n);   check("post_rst_os_a", 32'(n), 325);
    wait_tick(0, 400, n);   check("post_rst_os_b", 32'(n), 325);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
